// File: rtl/wave_capture_if.sv
// Measurement bus of the waveform capture block: strobed samples in,
// per-period results out on a valid/ready handshake, plus status flags.
interface wave_capture_if #(
  parameter int DATA_WIDTH   = 10,
  parameter int PERIOD_WIDTH = 24
);
  logic [DATA_WIDTH-1:0]   sample_in;
  logic                    sample_stb;
  logic [PERIOD_WIDTH-1:0] period_out;
  logic [DATA_WIDTH-1:0]   min_out;
  logic [DATA_WIDTH-1:0]   max_out;
  logic                    meas_valid;
  logic                    meas_ready;
  logic                    overrun;
  logic                    timeout;

  // Sample source and result consumer side
  modport master (
    output sample_in, sample_stb, meas_ready,
    input  period_out, min_out, max_out, meas_valid, overrun, timeout
  );

  // Capture block side
  modport slave (
    input  sample_in, sample_stb, meas_ready,
    output period_out, min_out, max_out, meas_valid, overrun, timeout
  );
endinterface

// File: rtl/wave_capture.sv
// Waveform period / min / max measurement.
// Rising crossings through a hysteresis band around midscale delimit periods.
// Each completed period is published as one result on a valid/ready
// handshake. A result that arrives while the previous one is still held
// is dropped and flagged through the sticky overrun bit.
module wave_capture #(
  parameter int DATA_WIDTH   = 10,
  parameter int MIDSCALE     = 512,
  parameter int HYST         = 16,
  parameter int PERIOD_WIDTH = 24
) (
  input  logic          clk,
  input  logic          rst_n,
  wave_capture_if.slave bus
);

  localparam logic [DATA_WIDTH-1:0]   LO_LEVEL = DATA_WIDTH'(MIDSCALE - HYST);
  localparam logic [DATA_WIDTH-1:0]   HI_LEVEL = DATA_WIDTH'(MIDSCALE + HYST);
  localparam logic [PERIOD_WIDTH-1:0] CNT_MAX  = {PERIOD_WIDTH{1'b1}};
  localparam logic [PERIOD_WIDTH-1:0] CNT_ONE  = PERIOD_WIDTH'(1);

  localparam logic [1:0] ST_ARM       = 2'd0;
  localparam logic [1:0] ST_WAIT_RISE = 2'd1;
  localparam logic [1:0] ST_HIGH      = 2'd2;
  localparam logic [1:0] ST_LOW       = 2'd3;

  logic [1:0]              state;
  logic [PERIOD_WIDTH-1:0] cnt;
  logic [DATA_WIDTH-1:0]   win_min;
  logic [DATA_WIDTH-1:0]   win_max;

  logic [PERIOD_WIDTH-1:0] period_q;
  logic [DATA_WIDTH-1:0]   min_q;
  logic [DATA_WIDTH-1:0]   max_q;
  logic                    valid_q;
  logic                    overrun_q;
  logic                    timeout_q;

  logic is_lo;
  logic is_hi;
  logic in_period;
  logic cnt_full;
  logic opening;
  logic closing;
  logic accept;
  logic load_result;
  logic drop_result;

  // Only strobed samples take part in level detection
  assign is_lo = bus.sample_stb && (bus.sample_in <= LO_LEVEL);
  assign is_hi = bus.sample_stb && (bus.sample_in >= HI_LEVEL);

  assign in_period = (state == ST_HIGH) || (state == ST_LOW);

  // A saturated counter abandons the period and wins over a crossing on the same edge
  assign cnt_full = in_period && (cnt == CNT_MAX);

  // A closing crossing is also the opening crossing of the next period
  assign closing = !cnt_full && (state == ST_LOW) && is_hi;
  assign opening = closing || ((state == ST_WAIT_RISE) && is_hi);

  assign accept      = valid_q && bus.meas_ready;
  assign load_result = closing && (!valid_q || bus.meas_ready);
  assign drop_result = closing && valid_q && !bus.meas_ready;

  // Crossing tracker: arm on a low sample, then alternate high/low phases
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_ARM;
    end else if (cnt_full) begin
      state <= ST_ARM;
    end else begin
      case (state)
        ST_ARM:       if (is_lo) state <= ST_WAIT_RISE;
        ST_WAIT_RISE: if (is_hi) state <= ST_HIGH;
        ST_HIGH:      if (is_lo) state <= ST_LOW;
        ST_LOW:       if (is_hi) state <= ST_HIGH;
        default:      state <= ST_ARM;
      endcase
    end
  end

  // Period counter runs on every clock inside a period, strobe or not
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (opening || cnt_full) begin
      cnt <= '0;
    end else if (in_period) begin
      cnt <= cnt + CNT_ONE;
    end
  end

  // Running min/max over the current window; the closing sample seeds the next one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_min <= '0;
      win_max <= '0;
    end else if (opening) begin
      win_min <= bus.sample_in;
      win_max <= bus.sample_in;
    end else if (in_period && bus.sample_stb) begin
      if (bus.sample_in < win_min) win_min <= bus.sample_in;
      if (bus.sample_in > win_max) win_max <= bus.sample_in;
    end
  end

  // Result holding register and valid flag of the output handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_q <= '0;
      min_q    <= '0;
      max_q    <= '0;
      valid_q  <= 1'b0;
    end else if (load_result) begin
      period_q <= cnt + CNT_ONE;
      min_q    <= win_min;
      max_q    <= win_max;
      valid_q  <= 1'b1;
    end else if (accept) begin
      valid_q  <= 1'b0;
    end
  end

  // Sticky overrun, released only by an accepted handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_q <= 1'b0;
    end else if (accept) begin
      overrun_q <= 1'b0;
    end else if (drop_result) begin
      overrun_q <= 1'b1;
    end
  end

  // One-cycle pulse when a period is abandoned on counter saturation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= cnt_full;
    end
  end

  assign bus.period_out = period_q;
  assign bus.min_out    = min_q;
  assign bus.max_out    = max_q;
  assign bus.meas_valid = valid_q;
  assign bus.overrun    = overrun_q;
  assign bus.timeout    = timeout_q;

endmodule

// File: tb/tb_wave_capture.sv
// Bench for wave_capture: a 24-bit-period instance and an 8-bit-period
// instance share clock and reset. A behavioural model, working from sample
// history and crossing times, predicts every output each cycle; directed
// scenarios add hand-computed literal expectations.
module tb_wave_capture;

  logic clk;
  logic rst_n;

  logic [9:0]  drv_sample  [2];
  logic        drv_stb     [2];
  logic        drv_ready   [2];

  logic [23:0] dut_period  [2];
  logic [9:0]  dut_min     [2];
  logic [9:0]  dut_max     [2];
  logic        dut_valid   [2];
  logic        dut_overrun [2];
  logic        dut_timeout [2];

  wave_capture_if #(.DATA_WIDTH(10), .PERIOD_WIDTH(24)) bus0 ();
  wave_capture_if #(.DATA_WIDTH(10), .PERIOD_WIDTH(8))  bus1 ();

  wave_capture #(.DATA_WIDTH(10), .MIDSCALE(512), .HYST(16), .PERIOD_WIDTH(24)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  wave_capture #(.DATA_WIDTH(10), .MIDSCALE(512), .HYST(16), .PERIOD_WIDTH(8)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  assign bus0.sample_in  = drv_sample[0];
  assign bus0.sample_stb = drv_stb[0];
  assign bus0.meas_ready = drv_ready[0];
  assign bus1.sample_in  = drv_sample[1];
  assign bus1.sample_stb = drv_stb[1];
  assign bus1.meas_ready = drv_ready[1];

  assign dut_period[0]  = bus0.period_out;
  assign dut_period[1]  = {16'd0, bus1.period_out};
  assign dut_min[0]     = bus0.min_out;
  assign dut_min[1]     = bus1.min_out;
  assign dut_max[0]     = bus0.max_out;
  assign dut_max[1]     = bus1.max_out;
  assign dut_valid[0]   = bus0.meas_valid;
  assign dut_valid[1]   = bus1.meas_valid;
  assign dut_overrun[0] = bus0.overrun;
  assign dut_overrun[1] = bus1.overrun;
  assign dut_timeout[0] = bus0.timeout;
  assign dut_timeout[1] = bus1.timeout;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: crossing bookkeeping and the sample window as a plain list
  int m_cycle     [2] = '{0, 0};
  int m_rise      [2] = '{0, 0};
  bit m_armed     [2] = '{0, 0};
  bit m_in_period [2] = '{0, 0};
  bit m_seen_lo   [2] = '{0, 0};
  int win0 [$];
  int win1 [$];

  bit exp_valid   [2] = '{0, 0};
  bit exp_overrun [2] = '{0, 0};
  bit exp_timeout [2] = '{0, 0};
  int exp_period  [2] = '{0, 0};
  int exp_min     [2] = '{0, 0};
  int exp_max     [2] = '{0, 0};

  // Observations gathered by applyStimulus for the directed literal checks
  int ev_valid_count;
  int ev_first_valid;
  int ev_first_period;
  int ev_first_min;
  int ev_first_max;
  int ev_last_period;
  int ev_last_min;
  int ev_last_max;
  int ev_timeouts;
  int ev_timeout_k;

  int ready_mode [2];
  bit rnd_level  [2];
  int sine_tab   [128];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_value(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int period_limit(input int d);
    return (d == 0) ? (1 << 24) : (1 << 8);
  endfunction

  task automatic win_clear(input int d);
    if (d == 0) win0.delete();
    else        win1.delete();
  endtask

  task automatic win_push(input int d, input int s);
    if (d == 0) win0.push_back(s);
    else        win1.push_back(s);
  endtask

  task automatic window_range(input int d, output int mn, output int mx);
    int n;
    int v;
    n  = (d == 0) ? win0.size() : win1.size();
    mn = 1 << 30;
    mx = -1;
    for (int i = 0; i < n; i++) begin
      v = (d == 0) ? win0[i] : win1[i];
      if (v < mn) mn = v;
      if (v > mx) mx = v;
    end
  endtask

  task automatic open_period(input int d, input int s);
    m_in_period[d] = 1'b1;
    m_seen_lo[d]   = 1'b0;
    m_rise[d]      = m_cycle[d];
    win_clear(d);
    win_push(d, s);
  endtask

  task automatic model_reset(input int d);
    m_cycle[d]     = 0;
    m_rise[d]      = 0;
    m_armed[d]     = 1'b0;
    m_in_period[d] = 1'b0;
    m_seen_lo[d]   = 1'b0;
    win_clear(d);
    exp_valid[d]   = 1'b0;
    exp_overrun[d] = 1'b0;
    exp_timeout[d] = 1'b0;
    exp_period[d]  = 0;
    exp_min[d]     = 0;
    exp_max[d]     = 0;
  endtask

  // One clock edge of the model: period = edges since the opening crossing
  task automatic model_step(input int d);
    int s;
    bit lo;
    bit hi;
    bit publish;
    bit handshake;
    int per;
    int mn;
    int mx;
    s         = int'(drv_sample[d]);
    lo        = drv_stb[d] && (s <= 496);
    hi        = drv_stb[d] && (s >= 528);
    publish   = 1'b0;
    per       = 0;
    mn        = 0;
    mx        = 0;
    handshake = exp_valid[d] && drv_ready[d];
    m_cycle[d]++;
    exp_timeout[d] = 1'b0;
    if (m_in_period[d] && (m_cycle[d] - m_rise[d]) == period_limit(d)) begin
      exp_timeout[d] = 1'b1;
      m_in_period[d] = 1'b0;
      m_armed[d]     = 1'b0;
    end else if (!m_in_period[d]) begin
      if (!m_armed[d]) begin
        if (lo) m_armed[d] = 1'b1;
      end else if (hi) begin
        open_period(d, s);
      end
    end else if (m_seen_lo[d] && hi) begin
      per = m_cycle[d] - m_rise[d];
      window_range(d, mn, mx);
      publish = 1'b1;
      open_period(d, s);
    end else if (drv_stb[d]) begin
      win_push(d, s);
      if (lo) m_seen_lo[d] = 1'b1;
    end

    if (publish) begin
      if (!exp_valid[d] || drv_ready[d]) begin
        exp_valid[d]  = 1'b1;
        exp_period[d] = per;
        exp_min[d]    = mn;
        exp_max[d]    = mx;
      end else begin
        exp_overrun[d] = 1'b1;
      end
    end else if (handshake) begin
      exp_valid[d] = 1'b0;
    end
    if (handshake) exp_overrun[d] = 1'b0;
  endtask

  // Model advances on the same edges as the DUTs
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_reset(0);
      model_reset(1);
    end else begin
      model_step(0);
      model_step(1);
    end
  end

  task automatic checkOutput(input int d);
    check_value($sformatf("dut%0d.meas_valid", d), dut_valid[d], exp_valid[d]);
    check_value($sformatf("dut%0d.overrun", d), dut_overrun[d], exp_overrun[d]);
    check_value($sformatf("dut%0d.timeout", d), dut_timeout[d], exp_timeout[d]);
    if (exp_valid[d]) begin
      check_value($sformatf("dut%0d.period_out", d), dut_period[d], exp_period[d]);
      check_value($sformatf("dut%0d.min_out", d), dut_min[d], exp_min[d]);
      check_value($sformatf("dut%0d.max_out", d), dut_max[d], exp_max[d]);
    end
  endtask

  // Compare every cycle, half a clock away from the active edge
  always @(negedge clk) begin
    checkOutput(0);
    checkOutput(1);
  end

  task automatic check_reset_outputs(input string tag);
    for (int d = 0; d < 2; d++) begin
      check_value($sformatf("%s dut%0d.meas_valid", tag, d), dut_valid[d], 0);
      check_value($sformatf("%s dut%0d.period_out", tag, d), dut_period[d], 0);
      check_value($sformatf("%s dut%0d.min_out", tag, d), dut_min[d], 0);
      check_value($sformatf("%s dut%0d.max_out", tag, d), dut_max[d], 0);
      check_value($sformatf("%s dut%0d.overrun", tag, d), dut_overrun[d], 0);
      check_value($sformatf("%s dut%0d.timeout", tag, d), dut_timeout[d], 0);
    end
  endtask

  task automatic record_events(input int d, input int k);
    if (dut_valid[d]) begin
      ev_valid_count++;
      if (ev_first_valid < 0) begin
        ev_first_valid  = k;
        ev_first_period = int'(dut_period[d]);
        ev_first_min    = int'(dut_min[d]);
        ev_first_max    = int'(dut_max[d]);
      end
      ev_last_period = int'(dut_period[d]);
      ev_last_min    = int'(dut_min[d]);
      ev_last_max    = int'(dut_max[d]);
    end
    if (dut_timeout[d]) begin
      ev_timeouts++;
      ev_timeout_k = k;
    end
  endtask

  task automatic drive_one(input int mode, input int j, input int idx);
    int bnd [7];
    bnd = '{496, 527, 528, 497, 496, 527, 528};
    case (mode)
      1: begin
        drv_stb[j]    = 1'b1;
        drv_sample[j] = (((idx / 100) % 2) == 1) ? 10'd1023 : 10'd0;
      end
      2: begin
        drv_stb[j]    = ((idx % 4) == 0);
        drv_sample[j] = 10'(sine_tab[(idx / 4) % 128]);
      end
      3: begin
        drv_stb[j]    = 1'b1;
        drv_sample[j] = (idx < 4) ? 10'd0 : (((idx % 2) == 1) ? 10'd520 : 10'd505);
      end
      4: begin
        drv_stb[j]    = 1'b1;
        drv_sample[j] = (idx < 10) ? 10'd0 : 10'd1023;
      end
      6: begin
        drv_stb[j]    = 1'b1;
        drv_sample[j] = 10'(bnd[(idx / 10 > 6) ? 6 : idx / 10]);
      end
      default: begin
        if ($urandom_range(0, (j == 0) ? 39 : 99) == 0) rnd_level[j] = !rnd_level[j];
        drv_stb[j] = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 9) == 0)
          drv_sample[j] = 10'($urandom_range(497, 527));
        else if (rnd_level[j])
          drv_sample[j] = 10'($urandom_range(528, 1023));
        else
          drv_sample[j] = 10'($urandom_range(0, 496));
      end
    endcase
    case (ready_mode[j])
      0:       drv_ready[j] = 1'b0;
      1:       drv_ready[j] = 1'b1;
      default: drv_ready[j] = ($urandom_range(0, 2) == 0);
    endcase
  endtask

  // Drive n cycles of waveform 'mode' into DUT d (mode 5 drives both), starting at index k0
  task automatic applyStimulus(input int mode, input int d, input int k0, input int n);
    ev_valid_count = 0;
    ev_first_valid = -1;
    ev_timeouts    = 0;
    ev_timeout_k   = -1;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      record_events(d, k);
      for (int j = 0; j < 2; j++) begin
        if (mode == 5 || j == d) begin
          drive_one(mode, j, k0 + k);
        end else begin
          drv_stb[j]   = 1'b0;
          drv_ready[j] = 1'b1;
        end
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    drv_stb[0] = 1'b0;
    drv_stb[1] = 1'b0;
    #2 rst_n = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 128; i++)
      sine_tab[i] = int'(511.5 + 511.5 * $sin(2.0 * 3.14159265358979 * real'(i) / 128.0));
    for (int j = 0; j < 2; j++) begin
      drv_sample[j] = '0;
      drv_stb[j]    = 1'b0;
      drv_ready[j]  = 1'b1;
      ready_mode[j] = 1;
      rnd_level[j]  = 1'b0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    #2 rst_n = 1'b1;

    $display("[TB] square wave, period 200");
    applyStimulus(1, 0, 0, 1000);
    check_value("sq first_valid_cycle", ev_first_valid, 301);
    check_value("sq period", ev_first_period, 200);
    check_value("sq min", ev_first_min, 0);
    check_value("sq max", ev_first_max, 1023);
    check_value("sq results", ev_valid_count, 4);

    $display("[TB] sampled sine, one strobe per 4 clocks");
    do_reset();
    applyStimulus(2, 0, 0, 2560);
    check_value("sine results", ev_valid_count, 3);
    check_value("sine first period", ev_first_period, 512);
    check_value("sine last period", ev_last_period, 512);
    check_value("sine min_le_4", ev_last_min <= 4, 1);
    check_value("sine max_ge_1019", ev_last_max >= 1019, 1);

    $display("[TB] threshold boundaries");
    do_reset();
    applyStimulus(6, 0, 0, 70);
    check_value("bnd first_valid_cycle", ev_first_valid, 61);
    check_value("bnd period", ev_first_period, 40);
    check_value("bnd min", ev_first_min, 496);
    check_value("bnd max", ev_first_max, 528);

    $display("[TB] in-band chatter");
    do_reset();
    applyStimulus(3, 0, 0, 2000);
    check_value("chatter0 results", ev_valid_count, 0);
    check_value("chatter0 timeouts", ev_timeouts, 0);
    applyStimulus(3, 1, 0, 600);
    check_value("chatter1 results", ev_valid_count, 0);
    check_value("chatter1 timeouts", ev_timeouts, 0);

    $display("[TB] back-pressure and overrun");
    do_reset();
    ready_mode[0] = 0;
    applyStimulus(1, 0, 0, 750);
    check_value("bp first_valid_cycle", ev_first_valid, 301);
    check_value("bp held valid", dut_valid[0], 1);
    check_value("bp held period", dut_period[0], 200);
    check_value("bp held min", dut_min[0], 0);
    check_value("bp held max", dut_max[0], 1023);
    check_value("bp overrun", dut_overrun[0], 1);
    ready_mode[0] = 1;
    applyStimulus(1, 0, 750, 1);
    ready_mode[0] = 0;
    applyStimulus(1, 0, 751, 2);
    check_value("bp valid after accept", ev_valid_count, 0);
    check_value("bp overrun cleared", dut_overrun[0], 0);

    $display("[TB] counter saturation on the 8-bit instance");
    do_reset();
    ready_mode[0] = 1;
    ready_mode[1] = 1;
    applyStimulus(4, 1, 0, 400);
    check_value("sat timeout pulses", ev_timeouts, 1);
    check_value("sat timeout cycle", ev_timeout_k, 267);
    check_value("sat results", ev_valid_count, 0);

    $display("[TB] reset while a result is held");
    do_reset();
    ready_mode[0] = 0;
    applyStimulus(1, 0, 0, 350);
    check_value("mid held valid", dut_valid[0], 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midreset");
    @(negedge clk);
    #2 rst_n = 1'b1;
    applyStimulus(1, 0, 150, 500);
    check_value("mid first_valid_cycle", ev_first_valid, 351);
    check_value("mid period", ev_first_period, 200);

    $display("[TB] randomized waveforms and back-pressure");
    do_reset();
    ready_mode[0] = 2;
    ready_mode[1] = 2;
    applyStimulus(5, 0, 0, 6000);
    check_value("rand results seen", ev_valid_count > 0, 1);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
